// File: rtl/mult_exhaustive_checker.sv
// Exhaustive functional checker for a candidate W x W multiplier.
// Sweeps every operand pair, compares the product returned LAT cycles later
// against the true A*B, and reports pass/fail, error count and first failure.
module mult_exhaustive_checker #(
  parameter int W   = 2,
  parameter int LAT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic [W-1:0]   dut_a,
  output logic [W-1:0]   dut_b,
  input  logic [2*W-1:0] dut_p,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   err_count,
  output logic           first_err_valid,
  output logic [W-1:0]   first_err_a,
  output logic [W-1:0]   first_err_b,
  output logic [2*W-1:0] first_err_p
);

  localparam int KW      = 2 * W;
  localparam int EW      = 2 * W + 1;
  // Delay-line entry layout: {valid, a, b, expected product}
  localparam int ENTRY_W = 1 + 2 * W + KW;
  localparam logic [KW-1:0] K_LAST     = '1;
  localparam logic [2:0]    DRAIN_LAST = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [2:0]         drain_cnt_q, drain_cnt_d;
  logic               launch;

  logic [ENTRY_W-1:0] drv_entry;
  logic [ENTRY_W-1:0] cmp_entry;
  logic               cmp_valid;
  logic [W-1:0]       cmp_a;
  logic [W-1:0]       cmp_b;
  logic [KW-1:0]      cmp_exp;
  logic               mismatch;

  logic [EW-1:0]      err_count_q;
  logic               first_err_valid_q;
  logic [W-1:0]       first_err_a_q;
  logic [W-1:0]       first_err_b_q;
  logic [KW-1:0]      first_err_p_q;

  // A start pulse is honoured only when no sweep is in flight
  assign launch = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Operands come straight from the vector register, so they hold the last
  // vector once the sweep finishes
  assign dut_a = k_q[W-1:0];
  assign dut_b = k_q[KW-1:W];

  // Vector currently on the candidate's inputs, tagged with its true product
  assign drv_entry = {(state_q == S_SWEEP), dut_a, dut_b, KW'(dut_a) * KW'(dut_b)};

  generate
    if (LAT == 0) begin : g_no_pipe
      assign cmp_entry = drv_entry;
    end else begin : g_pipe
      for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
        logic [ENTRY_W-1:0] stage_q;
        if (gi == 0) begin : g_head
          // First stage captures the vector whose drive cycle just ended
          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) stage_q <= '0;
            else        stage_q <= drv_entry;
          end
        end else begin : g_tail
          // Later stages shift the entry one cycle further
          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) stage_q <= '0;
            else        stage_q <= g_stage[gi-1].stage_q;
          end
        end
      end
      assign cmp_entry = g_stage[LAT-1].stage_q;
    end
  endgenerate

  assign {cmp_valid, cmp_a, cmp_b, cmp_exp} = cmp_entry;

  // Only an exact match clears the flag, so an unknown product is a failure
  always_comb begin
    mismatch = 1'b1;
    if (dut_p == cmp_exp) mismatch = 1'b0;
  end

  // State, vector index and drain counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next-state logic: sweep all vectors, drain the candidate pipeline, finish
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SWEEP;
          k_d     = '0;
        end
      end
      S_SWEEP: begin
        if (k_q == K_LAST) begin
          state_d     = (LAT > 0) ? S_DRAIN : S_DONE;
          drain_cnt_d = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) state_d = S_DONE;
        else                           drain_cnt_d = drain_cnt_q + 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result accumulation; a new sweep wipes the previous result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_err_a_q     <= '0;
      first_err_b_q     <= '0;
      first_err_p_q     <= '0;
    end else if (launch) begin
      err_count_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_err_a_q     <= '0;
      first_err_b_q     <= '0;
      first_err_p_q     <= '0;
    end else if (cmp_valid && mismatch) begin
      err_count_q <= err_count_q + EW'(1);
      if (!first_err_valid_q) begin
        first_err_valid_q <= 1'b1;
        first_err_a_q     <= cmp_a;
        first_err_b_q     <= cmp_b;
        first_err_p_q     <= dut_p;
      end
    end
  end

  assign busy            = (state_q == S_SWEEP) || (state_q == S_DRAIN);
  assign done            = (state_q == S_DONE);
  assign pass            = done && (err_count_q == '0);
  assign err_count       = err_count_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_a     = first_err_a_q;
  assign first_err_b     = first_err_b_q;
  assign first_err_p     = first_err_p_q;

endmodule

// File: tb/tb_mult_exhaustive_checker.sv
// Bench for mult_exhaustive_checker: three instances (W2/LAT0, W2/LAT2,
// W3/LAT1) driving bench-side candidate multipliers, checked every cycle
// against a sweep-level reference model.
module tb_mult_exhaustive_checker;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic [2:0] start_v = 3'b000;

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  int         mode [3];
  logic [5:0] flt  [3][64];

  // ---------------- instance 0 : W=2, LAT=0
  logic [1:0] a0, b0, fa0, fb0;
  logic [3:0] p0, fp0;
  logic [4:0] e0;
  logic       bz0, dn0, ps0, fv0;
  mult_exhaustive_checker #(.W(2), .LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .dut_a(a0), .dut_b(b0), .dut_p(p0),
    .busy(bz0), .done(dn0), .pass(ps0), .err_count(e0), .first_err_valid(fv0),
    .first_err_a(fa0), .first_err_b(fb0), .first_err_p(fp0));

  // ---------------- instance 1 : W=2, LAT=2
  logic [1:0] a1, b1, fa1, fb1;
  logic [3:0] p1, fp1;
  logic [4:0] e1;
  logic       bz1, dn1, ps1, fv1;
  mult_exhaustive_checker #(.W(2), .LAT(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .dut_a(a1), .dut_b(b1), .dut_p(p1),
    .busy(bz1), .done(dn1), .pass(ps1), .err_count(e1), .first_err_valid(fv1),
    .first_err_a(fa1), .first_err_b(fb1), .first_err_p(fp1));

  // ---------------- instance 2 : W=3, LAT=1
  logic [2:0] a2, b2, fa2, fb2;
  logic [5:0] p2, fp2;
  logic [6:0] e2;
  logic       bz2, dn2, ps2, fv2;
  mult_exhaustive_checker #(.W(3), .LAT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .dut_a(a2), .dut_b(b2), .dut_p(p2),
    .busy(bz2), .done(dn2), .pass(ps2), .err_count(e2), .first_err_valid(fv2),
    .first_err_a(fa2), .first_err_b(fb2), .first_err_p(fp2));

  function automatic int wi(input int i);
    return (i == 2) ? 3 : 2;
  endfunction

  function automatic int li(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
  endfunction

  function automatic int nvec(input int i);
    return 1 << (2 * wi(i));
  endfunction

  // Candidate multiplier behaviour for instance i, truncated to 2W bits
  function automatic int cand(input int i, input int a, input int b);
    int w, p, a0b, a1b, b0b, b1b;
    w   = wi(i);
    a0b = a & 1;
    a1b = (a >> 1) & 1;
    b0b = b & 1;
    b1b = (b >> 1) & 1;
    case (mode[i])
      0:       p = a * b;
      1:       p = 8 * (a0b & b1b) + 2 * ((1 - a1b) & b1b) + ((1 - a1b) & (1 - b0b));
      2:       p = (a == 7 && b == 7) ? 0 : a * b;
      default: p = (a * b) ^ int'(flt[i][(b << w) | a]);
    endcase
    return p & ((1 << (2 * w)) - 1);
  endfunction

  // Candidate netlists: combinational, two-stage and one-stage pipelined
  always_comb p0 = 4'(cand(0, int'(a0), int'(b0)));

  logic [3:0] p1_s1, p1_s2;
  always @(posedge clk) begin
    p1_s1 <= 4'(cand(1, int'(a1), int'(b1)));
    p1_s2 <= p1_s1;
  end
  assign p1 = p1_s2;

  always @(posedge clk) p2 <= 6'(cand(2, int'(a2), int'(b2)));

  // Uniform view of the three instances' outputs
  int o_a[3], o_b[3], o_err[3], o_fa[3], o_fb[3], o_fp[3];
  bit o_busy[3], o_done[3], o_pass[3], o_fv[3];
  always_comb begin
    o_a[0] = int'(a0); o_b[0] = int'(b0); o_err[0] = int'(e0);
    o_fa[0] = int'(fa0); o_fb[0] = int'(fb0); o_fp[0] = int'(fp0);
    o_busy[0] = bz0; o_done[0] = dn0; o_pass[0] = ps0; o_fv[0] = fv0;
    o_a[1] = int'(a1); o_b[1] = int'(b1); o_err[1] = int'(e1);
    o_fa[1] = int'(fa1); o_fb[1] = int'(fb1); o_fp[1] = int'(fp1);
    o_busy[1] = bz1; o_done[1] = dn1; o_pass[1] = ps1; o_fv[1] = fv1;
    o_a[2] = int'(a2); o_b[2] = int'(b2); o_err[2] = int'(e2);
    o_fa[2] = int'(fa2); o_fb[2] = int'(fb2); o_fp[2] = int'(fp2);
    o_busy[2] = bz2; o_done[2] = dn2; o_pass[2] = ps2; o_fv[2] = fv2;
  end

  task automatic chk(input string name, input int i, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0d required=%0d time=%0t", name, i, act, exp, $time);
    end
  endtask

  // Reference model: per instance, whether a sweep has been accepted, how many
  // edges have passed since the accepting edge, and the candidate's products
  // for every vector as they were when the sweep began.
  bit act  [3];
  int tcnt [3];
  int snap [3][64];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        act[i]  <= 1'b0;
        tcnt[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (start_v[i] && !(act[i] && tcnt[i] < nvec(i) + li(i))) begin
          act[i]  <= 1'b1;
          tcnt[i] <= 0;
          for (int k = 0; k < nvec(i); k++)
            snap[i][k] <= cand(i, k % (1 << wi(i)), k >> wi(i));
        end else if (act[i] && tcnt[i] < nvec(i) + li(i)) begin
          tcnt[i] <= tcnt[i] + 1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    int w, n, l, kd, e_a, e_b, e_err, e_fv, e_fa, e_fb, e_fp, e_busy, e_done;
    for (int i = 0; i < 3; i++) begin
      w = wi(i); n = nvec(i); l = li(i);
      e_a = 0; e_b = 0; e_err = 0; e_fv = 0; e_fa = 0; e_fb = 0; e_fp = 0;
      e_busy = 0; e_done = 0;
      if (act[i]) begin
        kd     = (tcnt[i] < n) ? tcnt[i] : n - 1;
        e_a    = kd % (1 << w);
        e_b    = kd >> w;
        e_busy = (tcnt[i] < n + l) ? 1 : 0;
        e_done = 1 - e_busy;
        for (int k = 0; k < n; k++) begin
          if (k + 1 + l <= tcnt[i] && snap[i][k] != (k % (1 << w)) * (k >> w)) begin
            e_err++;
            if (e_fv == 0) begin
              e_fv = 1; e_fa = k % (1 << w); e_fb = k >> w; e_fp = snap[i][k];
            end
          end
        end
      end
      chk("busy", i, int'(o_busy[i]), e_busy);
      chk("done", i, int'(o_done[i]), e_done);
      chk("pass", i, int'(o_pass[i]), (e_done == 1 && e_err == 0) ? 1 : 0);
      chk("dut_a", i, o_a[i], e_a);
      chk("dut_b", i, o_b[i], e_b);
      chk("err_count", i, o_err[i], e_err);
      chk("first_err_valid", i, int'(o_fv[i]), e_fv);
      chk("first_err_a", i, o_fa[i], e_fa);
      chk("first_err_b", i, o_fb[i], e_fb);
      chk("first_err_p", i, o_fp[i], e_fp);
    end
  end

  // Called at a falling edge; the following rising edge samples start
  task automatic pulse_start(input int i);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  // Waits for done, checks the start-to-done latency and logs the sweep
  task automatic wait_done(input int i, input int elapsed, input string tag);
    int c;
    c = elapsed;
    while (!o_done[i] && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_latency"}, i, c, nvec(i) + li(i));
    $display("sweep %s inst=%0d cycles=%0d err=%0d pass=%0d first_valid=%0d first=(a=%0d b=%0d p=%0d)",
             tag, i, c, o_err[i], o_pass[i], o_fv[i], o_fa[i], o_fb[i], o_fp[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog inst=-1 actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      mode[i] = 0;
      for (int k = 0; k < 64; k++) flt[i][k] = 6'd0;
    end
    #23 rst_n = 1'b1;
    @(negedge clk);

    // Correct combinational candidate
    pulse_start(0);
    wait_done(0, 0, "s1");
    chk("s1_pass", 0, int'(o_pass[0]), 1);
    chk("s1_err", 0, o_err[0], 0);
    chk("s1_fv", 0, int'(o_fv[0]), 0);

    // Faulty 2x2 candidate
    mode[0] = 1;
    pulse_start(0);
    wait_done(0, 0, "s2");
    chk("s2_err", 0, o_err[0], 13);
    chk("s2_pass", 0, int'(o_pass[0]), 0);
    chk("s2_fv", 0, int'(o_fv[0]), 1);
    chk("s2_fa", 0, o_fa[0], 0);
    chk("s2_fb", 0, o_fb[0], 0);
    chk("s2_fp", 0, o_fp[0], 1);

    // Same faulty candidate with a start pulse while busy
    pulse_start(0);
    repeat (4) @(negedge clk);
    pulse_start(0);
    wait_done(0, 5, "s4a");
    chk("s4a_err", 0, o_err[0], 13);
    chk("s4a_fv", 0, int'(o_fv[0]), 1);
    chk("s4a_fp", 0, o_fp[0], 1);

    // Restart from DONE with a correct candidate: results clear at once
    mode[0] = 0;
    pulse_start(0);
    chk("s4b_done_cleared", 0, int'(o_done[0]), 0);
    chk("s4b_err_cleared", 0, o_err[0], 0);
    chk("s4b_fv_cleared", 0, int'(o_fv[0]), 0);
    wait_done(0, 0, "s4b");
    chk("s4b_pass", 0, int'(o_pass[0]), 1);

    // Two-stage pipelined correct candidate
    pulse_start(1);
    wait_done(1, 0, "s3");
    chk("s3_pass", 1, int'(o_pass[1]), 1);
    chk("s3_err", 1, o_err[1], 0);

    // 3-bit candidate with a single fault at 7*7
    mode[2] = 2;
    pulse_start(2);
    wait_done(2, 0, "s6");
    chk("s6_err", 2, o_err[2], 1);
    chk("s6_fa", 2, o_fa[2], 7);
    chk("s6_fb", 2, o_fb[2], 7);
    chk("s6_fp", 2, o_fp[2], 0);
    chk("s6_pass", 2, int'(o_pass[2]), 0);

    // Asynchronous reset in the middle of a failing sweep
    mode[0] = 1;
    pulse_start(0);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_busy", 0, int'(o_busy[0]), 0);
    chk("s5_done", 0, int'(o_done[0]), 0);
    chk("s5_dut_a", 0, o_a[0], 0);
    chk("s5_dut_b", 0, o_b[0], 0);
    chk("s5_err", 0, o_err[0], 0);
    chk("s5_fv", 0, int'(o_fv[0]), 0);
    chk("s5_err_inst2", 2, o_err[2], 0);
    chk("s5_fa_inst2", 2, o_fa[2], 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("s5_idle_busy", 0, int'(o_busy[0]), 0);
    chk("s5_idle_done", 0, int'(o_done[0]), 0);
    mode[0] = 0;
    pulse_start(0);
    wait_done(0, 0, "s5");
    chk("s5_pass", 0, int'(o_pass[0]), 1);

    // Random fault tables, random gaps and random ignored start pulses
    for (int r = 0; r < 6; r++) begin
      int ii, extra, d;
      ii = int'($urandom_range(0, 2));
      mode[ii] = 3;
      for (int k = 0; k < 64; k++)
        flt[ii][k] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse_start(ii);
      extra = 0;
      if ($urandom_range(0, 1) == 1) begin
        d = int'($urandom_range(1, 8));
        repeat (d - 1) @(negedge clk);
        pulse_start(ii);
        extra = d;
      end
      wait_done(ii, extra, "rnd");
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
